reg_bus_arbiter: RTL and testbench
==================================

Name: reg_bus_arbiter

Overview:
- Shares one register-bus target (reg_block, fed by the AXI4-Lite register bridge) between NUM_REQ independent register-bus requesters, e.g. the AXI4-Lite bridge plus a debug/UART command master.
- Round-robin arbitration, one transaction outstanding at a time.
- Requests are forwarded unchanged; rdata, ack and err are routed back only to the granted requester.
- Sits between the requesters' reg_* outputs and the single reg_block reg_* inputs.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- REG_ADDR_WIDTH, 16, register address width.
- REG_DATA_WIDTH, 32, register data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 64, downstream ack timeout in cycles. Used only with REG_ARB_TIMEOUT_EN. Must be ≥ 2.

Ports:
- axi4l_aclk  in  1  clock; all logic on the rising edge.
- axi4l_arstn  in  1  reset: asynchronous, active-high.
- s_reg_req  in  NUM_REQ  per-requester request level.
- s_reg_addr  in  NUM_REQ*REG_ADDR_WIDTH  packed addresses; requester i at slice i.
- s_reg_wdata  in  NUM_REQ*REG_DATA_WIDTH  packed write data.
- s_reg_wren  in  NUM_REQ  1 = write, 0 = read.
- s_reg_be  in  NUM_REQ*(REG_DATA_WIDTH/8)  packed byte enables.
- s_reg_ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
- s_reg_err  out  NUM_REQ  error flag; valid with s_reg_ack.
- s_reg_rdata  out  REG_DATA_WIDTH  read data, shared by all requesters; valid with any s_reg_ack bit.
- m_reg_req  out  1  request to target.
- m_reg_addr  out  REG_ADDR_WIDTH  address to target.
- m_reg_wdata  out  REG_DATA_WIDTH  write data to target.
- m_reg_wren  out  1  write strobe qualifier.
- m_reg_be  out  REG_DATA_WIDTH/8  byte enables.
- m_reg_rdata  in  REG_DATA_WIDTH  target read data.
- m_reg_ack  in  1  target completion pulse.
- m_reg_err  in  1  target error; valid with m_reg_ack.
- grant  out  NUM_REQ  one-hot current owner; 0 when idle (debug/visibility).

Behaviour:
Requester protocol:
- A requester raises s_reg_req with addr, wdata, wren and be stable, and holds them until its s_reg_ack pulse.
- It must deassert s_reg_req on the cycle after the ack. It may re-raise s_reg_req no earlier than one cycle after that deassertion.

Reset values (while axi4l_arstn = 1):
- All outputs 0; grant = 0.
- Round-robin pointer = requester 0 has highest priority.
- FSM in IDLE.

FSM states:
- IDLE: if any s_reg_req bit is set, select the first set bit starting at the pointer and wrapping modulo NUM_REQ. Register grant, latch that requester's addr, wdata, wren and be into m_reg_*, and go to BUSY.
- BUSY: m_reg_req = 1 and m_reg_* held constant. When m_reg_ack = 1, register m_reg_rdata and m_reg_err into s_reg_rdata and s_reg_err, and go to RESP.
- RESP: s_reg_ack[grant] = 1 for exactly this cycle; m_reg_req = 0. Pointer = (granted index + 1) mod NUM_REQ. Clear grant and go to IDLE.

Timing and latency:
- Request-to-m_reg_req latency: 1 cycle.
- m_reg_ack to s_reg_ack latency: 1 cycle.
- Minimum transaction spacing: 3 cycles (IDLE, BUSY, RESP).

Output rules:
- s_reg_rdata holds its last value outside RESP.
- s_reg_err is driven only on the granted bit, and only in RESP.
- m_reg_ack while in IDLE or RESP: ignored. The sticky internal flag spurious_ack is set; it is visible only in simulation assertions.

Arbitration:
- Simultaneous requests: exactly one winner, chosen per the pointer. Losers keep s_reg_req high and are served in a later IDLE.
- A requester that deasserts s_reg_req before being granted is simply dropped.

Reset mid-operation:
- Asynchronous return to IDLE with all outputs 0.
- The in-flight transaction is abandoned; no s_reg_ack is issued.

Optional Feature:
- Macro: REG_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If the counter reaches TIMEOUT_CYCLES without m_reg_ack, go to RESP with s_reg_err = 1 and s_reg_rdata = 32'hDEADBEEF (truncated or zero-extended to REG_DATA_WIDTH), and drop m_reg_req.
  - m_reg_ack arriving in the same cycle the count hits TIMEOUT_CYCLES wins: it is a normal completion.
- When undefined: no counter is built, and BUSY waits indefinitely for m_reg_ack.

Test Plan:
1. Single read: requester 0 reads addr 16'h0004; target acks with rdata 32'hA5A5_0001, err 0, after 3 cycles. Expect m_reg_req 1 cycle after s_reg_req, s_reg_ack = 2'b01 one cycle after m_reg_ack, s_reg_rdata = 32'hA5A5_0001, s_reg_err = 0.
2. Contention after reset: both requesters raise req in the same cycle. Expect grant 2'b01 first, then 2'b10. On a further simultaneous request, expect 2'b01 again (rotation verified over 4 rounds, no starvation).
3. Write with error: requester 1 writes addr 16'h0004, wdata 32'h1234_5678, be 4'b0011 to a read-only register; target returns err 1. Expect m_reg_be = 4'b0011, m_reg_wdata passed unchanged, s_reg_ack = 2'b10, s_reg_err = 2'b10.
4. Reset mid-BUSY: assert axi4l_arstn while m_reg_req = 1. Expect m_reg_req = 0 and grant = 0 immediately (asynchronously), no s_reg_ack, and requester 0 has priority after release.
5. Timeout (REG_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): target never acks. Expect s_reg_ack with err 1 and rdata 32'hDEADBEEF, with s_reg_ack exactly 10 cycles after s_reg_req. Also: ack on the 8th BUSY cycle completes normally with err 0.
6. Spurious ack: pulse m_reg_ack in IDLE. Expect no s_reg_ack, FSM stays in IDLE, and spurious_ack = 1.

Source files
------------

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register-bus target among NUM_REQ
// requesters, one transaction outstanding at a time.
// Ports: axi4l_aclk/axi4l_arstn (async, active-high reset);
//   s_reg_* : packed requester side (req/addr/wdata/wren/be in,
//             ack/err per requester, shared rdata out);
//   m_reg_* : single target side; grant : one-hot current owner.
// Optional macro REG_ARB_TIMEOUT_EN adds a downstream ack timeout of
// TIMEOUT_CYCLES that completes with err=1 and rdata=DEADBEEF.
module reg_bus_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int REG_ADDR_WIDTH = 16,
    parameter int REG_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                   axi4l_aclk,
    input  logic                                   axi4l_arstn,
    input  logic [NUM_REQ-1:0]                     s_reg_req,
    input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]      s_reg_addr,
    input  logic [NUM_REQ*REG_DATA_WIDTH-1:0]      s_reg_wdata,
    input  logic [NUM_REQ-1:0]                     s_reg_wren,
    input  logic [NUM_REQ*(REG_DATA_WIDTH/8)-1:0]  s_reg_be,
    output logic [NUM_REQ-1:0]                     s_reg_ack,
    output logic [NUM_REQ-1:0]                     s_reg_err,
    output logic [REG_DATA_WIDTH-1:0]              s_reg_rdata,
    output logic                                   m_reg_req,
    output logic [REG_ADDR_WIDTH-1:0]              m_reg_addr,
    output logic [REG_DATA_WIDTH-1:0]              m_reg_wdata,
    output logic                                   m_reg_wren,
    output logic [REG_DATA_WIDTH/8-1:0]            m_reg_be,
    input  logic [REG_DATA_WIDTH-1:0]              m_reg_rdata,
    input  logic                                   m_reg_ack,
    input  logic                                   m_reg_err,
    output logic [NUM_REQ-1:0]                     grant
);

    localparam int AW = REG_ADDR_WIDTH;
    localparam int DW = REG_DATA_WIDTH;
    localparam int BW = REG_DATA_WIDTH / 8;
    localparam int IW = $clog2(NUM_REQ);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || (DW % 8) != 0 ||
            TIMEOUT_CYCLES < 2) begin : g_bad_cfg
            $error("reg_bus_arbiter: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic              m_req_q, m_req_d;
    logic [AW-1:0]     m_addr_q, m_addr_d;
    logic [DW-1:0]     m_wdata_q, m_wdata_d;
    logic              m_wren_q, m_wren_d;
    logic [BW-1:0]     m_be_q, m_be_d;
    logic [NUM_REQ-1:0] s_ack_q, s_ack_d;
    logic [NUM_REQ-1:0] s_err_q, s_err_d;
    logic [DW-1:0]     s_rdata_q, s_rdata_d;
    logic              spurious_ack_q, spurious_ack_d;
    logic              spurious_ack;

`ifdef REG_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] TO_RDATA = DW'(32'hDEAD_BEEF);
    logic [CW-1:0]     cnt_q, cnt_d;
`endif

    // First set request at or after the pointer, wrapping around.
    logic              found;
    logic [IW-1:0]     sel;
    logic [IW:0]       cand;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_REQ))
                cand = cand - (IW+1)'(NUM_REQ);
            if (!found && s_reg_req[cand[IW-1:0]]) begin
                found = 1'b1;
                sel   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        idx_d          = idx_q;
        ptr_d          = ptr_q;
        m_req_d        = m_req_q;
        m_addr_d       = m_addr_q;
        m_wdata_d      = m_wdata_q;
        m_wren_d       = m_wren_q;
        m_be_d         = m_be_q;
        s_ack_d        = s_ack_q;
        s_err_d        = s_err_q;
        s_rdata_d      = s_rdata_q;
        spurious_ack_d = spurious_ack_q;
`ifdef REG_ARB_TIMEOUT_EN
        cnt_d          = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (m_reg_ack)
                    spurious_ack_d = 1'b1;
                if (found) begin
                    state_d       = BUSY;
                    grant_d       = '0;
                    grant_d[sel]  = 1'b1;
                    idx_d         = sel;
                    m_req_d       = 1'b1;
                    m_addr_d      = s_reg_addr[int'(sel)*AW +: AW];
                    m_wdata_d     = s_reg_wdata[int'(sel)*DW +: DW];
                    m_wren_d      = s_reg_wren[sel];
                    m_be_d        = s_reg_be[int'(sel)*BW +: BW];
`ifdef REG_ARB_TIMEOUT_EN
                    cnt_d         = '0;
`endif
                end
            end
            BUSY: begin
                // A real ack always beats a timeout in the same cycle.
                if (m_reg_ack) begin
                    state_d   = RESP;
                    m_req_d   = 1'b0;
                    s_ack_d   = grant_q;
                    s_err_d   = m_reg_err ? grant_q : '0;
                    s_rdata_d = m_reg_rdata;
                end
`ifdef REG_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
                    state_d   = RESP;
                    m_req_d   = 1'b0;
                    s_ack_d   = grant_q;
                    s_err_d   = grant_q;
                    s_rdata_d = TO_RDATA;
                end else begin
                    cnt_d     = cnt_q + CW'(1);
                end
`endif
            end
            RESP: begin
                if (m_reg_ack)
                    spurious_ack_d = 1'b1;
                state_d = IDLE;
                s_ack_d = '0;
                s_err_d = '0;
                grant_d = '0;
                ptr_d   = (idx_q == IW'(NUM_REQ - 1)) ? '0
                                                      : idx_q + IW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi4l_aclk or posedge axi4l_arstn) begin
        if (axi4l_arstn) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            idx_q          <= '0;
            ptr_q          <= '0;
            m_req_q        <= 1'b0;
            m_addr_q       <= '0;
            m_wdata_q      <= '0;
            m_wren_q       <= 1'b0;
            m_be_q         <= '0;
            s_ack_q        <= '0;
            s_err_q        <= '0;
            s_rdata_q      <= '0;
            spurious_ack_q <= 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
            cnt_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            idx_q          <= idx_d;
            ptr_q          <= ptr_d;
            m_req_q        <= m_req_d;
            m_addr_q       <= m_addr_d;
            m_wdata_q      <= m_wdata_d;
            m_wren_q       <= m_wren_d;
            m_be_q         <= m_be_d;
            s_ack_q        <= s_ack_d;
            s_err_q        <= s_err_d;
            s_rdata_q      <= s_rdata_d;
            spurious_ack_q <= spurious_ack_d;
`ifdef REG_ARB_TIMEOUT_EN
            cnt_q          <= cnt_d;
`endif
        end
    end

    assign grant        = grant_q;
    assign m_reg_req    = m_req_q;
    assign m_reg_addr   = m_addr_q;
    assign m_reg_wdata  = m_wdata_q;
    assign m_reg_wren   = m_wren_q;
    assign m_reg_be     = m_be_q;
    assign s_reg_ack    = s_ack_q;
    assign s_reg_err    = s_err_q;
    assign s_reg_rdata  = s_rdata_q;
    assign spurious_ack = spurious_ack_q;

`ifndef SYNTHESIS
    // An ignored ack leaves a sticky mark until the next reset.
    spurious_sticky_a : assert property (
        @(posedge axi4l_aclk) disable iff (axi4l_arstn)
        spurious_ack |=> spurious_ack);
`endif

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed self-checking bench for reg_bus_arbiter (2 requesters).
// Build with +define+REG_ARB_TIMEOUT_EN to also exercise the timeout.
module tb_reg_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int BW = 4;

    logic              clk   = 1'b0;
    logic              arstn = 1'b0;
    logic [N-1:0]      s_reg_req   = '0;
    logic [N*AW-1:0]   s_reg_addr  = '0;
    logic [N*DW-1:0]   s_reg_wdata = '0;
    logic [N-1:0]      s_reg_wren  = '0;
    logic [N*BW-1:0]   s_reg_be    = '0;
    logic [N-1:0]      s_reg_ack;
    logic [N-1:0]      s_reg_err;
    logic [DW-1:0]     s_reg_rdata;
    logic              m_reg_req;
    logic [AW-1:0]     m_reg_addr;
    logic [DW-1:0]     m_reg_wdata;
    logic              m_reg_wren;
    logic [BW-1:0]     m_reg_be;
    logic [DW-1:0]     m_reg_rdata = '0;
    logic              m_reg_ack   = 1'b0;
    logic              m_reg_err   = 1'b0;
    logic [N-1:0]      grant;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;
    int lat;

    reg_bus_arbiter #(
        .NUM_REQ(N), .REG_ADDR_WIDTH(AW),
        .REG_DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
    ) dut (
        .axi4l_aclk(clk), .axi4l_arstn(arstn),
        .s_reg_req(s_reg_req), .s_reg_addr(s_reg_addr),
        .s_reg_wdata(s_reg_wdata), .s_reg_wren(s_reg_wren),
        .s_reg_be(s_reg_be), .s_reg_ack(s_reg_ack),
        .s_reg_err(s_reg_err), .s_reg_rdata(s_reg_rdata),
        .m_reg_req(m_reg_req), .m_reg_addr(m_reg_addr),
        .m_reg_wdata(m_reg_wdata), .m_reg_wren(m_reg_wren),
        .m_reg_be(m_reg_be), .m_reg_rdata(m_reg_rdata),
        .m_reg_ack(m_reg_ack), .m_reg_err(m_reg_err),
        .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic rq,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic w, input logic [BW-1:0] b);
        s_reg_req[i]             = rq;
        s_reg_addr[i*AW +: AW]   = a;
        s_reg_wdata[i*DW +: DW]  = d;
        s_reg_wren[i]            = w;
        s_reg_be[i*BW +: BW]     = b;
    endtask

    // One full grant/ack/response round for the expected winner g.
    task automatic serve(input logic [N-1:0] g, input logic [DW-1:0] rd,
                         input string tag);
        tick();
        check({tag, "_grant"}, 32'(grant), 32'(g));
        check({tag, "_mreq"}, 32'(m_reg_req), 32'd1);
        m_reg_ack   = 1'b1;
        m_reg_rdata = rd;
        m_reg_err   = 1'b0;
        tick();
        m_reg_ack = 1'b0;
        check({tag, "_ack"}, 32'(s_reg_ack), 32'(g));
        check({tag, "_rdata"}, s_reg_rdata, rd);
        for (int i = 0; i < N; i++)
            if (g[i]) s_reg_req[i] = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        #1 arstn = 1'b1;
        tick();
        tick();
        arstn = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        #1 arstn = 1'b1;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_mreq", 32'(m_reg_req), 32'd0);
        check("rst_ack", 32'(s_reg_ack), 32'd0);
        check("rst_err", 32'(s_reg_err), 32'd0);
        check("rst_rdata", s_reg_rdata, 32'd0);
        tick();
        tick();
        arstn = 1'b0;
        tick();

        // 1. Single read by requester 0
        drive(0, 1'b1, 16'h0004, 32'h0, 1'b0, 4'hF);
        check("t1_mreq_same", 32'(m_reg_req), 32'd0);
        tick();
        check("t1_mreq", 32'(m_reg_req), 32'd1);
        check("t1_grant", 32'(grant), 32'd1);
        check("t1_addr", 32'(m_reg_addr), 32'h0004);
        check("t1_wren", 32'(m_reg_wren), 32'd0);
        tick();
        tick();
        m_reg_ack   = 1'b1;
        m_reg_rdata = 32'hA5A5_0001;
        m_reg_err   = 1'b0;
        check("t1_noack", 32'(s_reg_ack), 32'd0);
        tick();
        m_reg_ack = 1'b0;
        check("t1_ack", 32'(s_reg_ack), 32'b01);
        check("t1_rdata", s_reg_rdata, 32'hA5A5_0001);
        check("t1_err", 32'(s_reg_err), 32'd0);
        check("t1_mreq_low", 32'(m_reg_req), 32'd0);
        drive(0, 1'b0, 16'h0004, 32'h0, 1'b0, 4'hF);
        tick();
        check("t1_ack_gone", 32'(s_reg_ack), 32'd0);
        check("t1_grant_idle", 32'(grant), 32'd0);
        check("t1_rdata_hold", s_reg_rdata, 32'hA5A5_0001);

        // 2. Contention after reset, four rounds
        do_reset();
        for (int r = 0; r < 4; r++) begin
            drive(0, 1'b1, 16'h0100, 32'h0, 1'b0, 4'hF);
            drive(1, 1'b1, 16'h0200, 32'h0, 1'b0, 4'hF);
            serve(2'b01, 32'h1000 + r, "t2_a");
            serve(2'b10, 32'h2000 + r, "t2_b");
        end
        // Pointer after serving requester 0 alone favours requester 1
        drive(0, 1'b1, 16'h0100, 32'h0, 1'b0, 4'hF);
        serve(2'b01, 32'h3000, "t2_solo");
        drive(0, 1'b1, 16'h0100, 32'h0, 1'b0, 4'hF);
        drive(1, 1'b1, 16'h0200, 32'h0, 1'b0, 4'hF);
        serve(2'b10, 32'h3001, "t2_rot_b");
        serve(2'b01, 32'h3002, "t2_rot_a");

        // 3. Write with error from requester 1
        drive(1, 1'b1, 16'h0004, 32'h1234_5678, 1'b1, 4'b0011);
        tick();
        check("t3_grant", 32'(grant), 32'b10);
        check("t3_addr", 32'(m_reg_addr), 32'h0004);
        check("t3_wdata", m_reg_wdata, 32'h1234_5678);
        check("t3_be", 32'(m_reg_be), 32'b0011);
        check("t3_wren", 32'(m_reg_wren), 32'd1);
        m_reg_ack = 1'b1;
        m_reg_err = 1'b1;
        tick();
        m_reg_ack = 1'b0;
        m_reg_err = 1'b0;
        check("t3_ack", 32'(s_reg_ack), 32'b10);
        check("t3_err", 32'(s_reg_err), 32'b10);
        drive(1, 1'b0, 16'h0004, 32'h1234_5678, 1'b1, 4'b0011);
        tick();
        check("t3_err_clr", 32'(s_reg_err), 32'd0);

        // 4. Reset mid-BUSY with pointer at requester 1
        drive(0, 1'b1, 16'h0008, 32'h0, 1'b0, 4'hF);
        serve(2'b01, 32'h4000, "t4_pre");
        drive(0, 1'b1, 16'h0008, 32'h0, 1'b0, 4'hF);
        tick();
        check("t4_busy", 32'(m_reg_req), 32'd1);
        #2 arstn = 1'b1;
        #1;
        check("t4_mreq_async", 32'(m_reg_req), 32'd0);
        check("t4_grant_async", 32'(grant), 32'd0);
        check("t4_ack_async", 32'(s_reg_ack), 32'd0);
        drive(0, 1'b0, 16'h0008, 32'h0, 1'b0, 4'hF);
        tick();
        tick();
        arstn = 1'b0;
        tick();
        check("t4_noack", 32'(s_reg_ack), 32'd0);
        drive(0, 1'b1, 16'h0100, 32'h0, 1'b0, 4'hF);
        drive(1, 1'b1, 16'h0200, 32'h0, 1'b0, 4'hF);
        serve(2'b01, 32'h4001, "t4_prio");
        serve(2'b10, 32'h4002, "t4_next");

        // 6. Spurious ack in IDLE
        check("t6_spur_pre", 32'(dut.spurious_ack), 32'd0);
        m_reg_ack = 1'b1;
        tick();
        m_reg_ack = 1'b0;
        check("t6_noack", 32'(s_reg_ack), 32'd0);
        check("t6_mreq", 32'(m_reg_req), 32'd0);
        check("t6_grant", 32'(grant), 32'd0);
        check("t6_spur", 32'(dut.spurious_ack), 32'd1);
        tick();
        check("t6_noack2", 32'(s_reg_ack), 32'd0);
        drive(1, 1'b1, 16'h0300, 32'h0, 1'b0, 4'hF);
        serve(2'b10, 32'h6000, "t6_after");
        check("t6_spur_sticky", 32'(dut.spurious_ack), 32'd1);

`ifdef REG_ARB_TIMEOUT_EN
        // 5. Timeout with TIMEOUT_CYCLES = 8
        drive(0, 1'b1, 16'h0010, 32'h0, 1'b0, 4'hF);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (s_reg_ack != '0) begin
                lat = k;
                break;
            end
        end
        check("t5_latency", 32'(lat), 32'd10);
        check("t5_ack", 32'(s_reg_ack), 32'b01);
        check("t5_err", 32'(s_reg_err), 32'b01);
        check("t5_rdata", s_reg_rdata, 32'hDEAD_BEEF);
        check("t5_mreq", 32'(m_reg_req), 32'd0);
        drive(0, 1'b0, 16'h0010, 32'h0, 1'b0, 4'hF);
        tick();
        // Ack on the 8th and on the 9th (boundary) BUSY cycle
        for (int n = 8; n <= 9; n++) begin
            drive(1, 1'b1, 16'h0014, 32'h0, 1'b0, 4'hF);
            tick();
            repeat (n - 1) tick();
            m_reg_ack   = 1'b1;
            m_reg_rdata = 32'h0000_0077 + n;
            m_reg_err   = 1'b0;
            tick();
            m_reg_ack = 1'b0;
            check("t5_late_ack", 32'(s_reg_ack), 32'b10);
            check("t5_late_err", 32'(s_reg_err), 32'd0);
            check("t5_late_rdata", s_reg_rdata, 32'h0000_0077 + n);
            drive(1, 1'b0, 16'h0014, 32'h0, 1'b0, 4'hF);
            tick();
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
